// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - binary16 field widths, bias, special constants and converter FSM states
package fp16_pkg;

  localparam int          FP16_EXP_W    = 5;
  localparam int          FP16_MAN_W    = 10;
  localparam int          FP16_BIAS     = 15;
  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;

  // Starting exponent for an un-normalised 16-bit magnitude (MSB at bit 15)
  localparam logic [FP16_EXP_W-1:0] EXP_CNT_INIT = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } conv_state_e;

endpackage

// File: rtl/fp16_round_pack.sv
// rtl/fp16_round_pack.sv - combinational round-and-pack of a normalised magnitude into binary16
// ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the mantissa is truncated toward zero.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic                  sign_i,
  input  logic [FP16_EXP_W-1:0] exp_cnt_i,
  input  logic [15:0]           mag_i,
  output logic [15:0]           r_o,
  output logic                  inexact_o
);

  logic [FP16_MAN_W-1:0] man;
  logic                  guard;
  logic                  sticky;
  logic [FP16_EXP_W-1:0] exp_biased;
  logic [FP16_MAN_W-1:0] man_out;
  logic [FP16_EXP_W-1:0] exp_out;
`ifdef ROUND_NEAREST_EN
  logic                  round_up;
  logic [FP16_MAN_W:0]   man_sum;
`endif

  always_comb begin
    man        = mag_i[14 -: FP16_MAN_W];
    guard      = mag_i[4];
    sticky     = |mag_i[3:0];
    exp_biased = exp_cnt_i + FP16_EXP_W'(FP16_BIAS);
    inexact_o  = guard | sticky;
`ifdef ROUND_NEAREST_EN
    round_up = guard & (sticky | man[0]);
    man_sum  = {1'b0, man} + {{FP16_MAN_W{1'b0}}, round_up};
    // Carry out of the mantissa means the value reached the next power of two
    if (man_sum[FP16_MAN_W]) begin
      man_out = '0;
      exp_out = exp_biased + 1'b1;
    end else begin
      man_out = man_sum[FP16_MAN_W-1:0];
      exp_out = exp_biased;
    end
`else
    man_out = man;
    exp_out = exp_biased;
`endif
    if (mag_i == 16'd0) begin
      r_o = FP16_POS_ZERO;
    end else begin
      r_o = {sign_i, exp_out, man_out};
    end
  end

endmodule

// File: rtl/int_to_fp_converter.sv
// rtl/int_to_fp_converter.sv - iterative signed int16 to binary16 converter, one normalise shift per cycle
// ROUND_NEAREST_EN (in fp16_round_pack) selects round-to-nearest-even instead of truncation.
module int_to_fp_converter
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic        negative,
  output logic        zero,
  output logic        inexact,
  output logic        busy
);

  conv_state_e           state_q, state_d;
  logic                  sign_q, sign_d;
  logic [15:0]           mag_q, mag_d;
  logic [FP16_EXP_W-1:0] exp_cnt_q, exp_cnt_d;
  logic [15:0]           r_q, r_d;
  logic                  negative_q, negative_d;
  logic                  zero_q, zero_d;
  logic                  inexact_q, inexact_d;

  logic [15:0]           pack_r;
  logic                  pack_inexact;

  fp16_round_pack u_round_pack (
    .sign_i    (sign_q),
    .exp_cnt_i (exp_cnt_q),
    .mag_i     (mag_q),
    .r_o       (pack_r),
    .inexact_o (pack_inexact)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      exp_cnt_q  <= '0;
      r_q        <= '0;
      negative_q <= 1'b0;
      zero_q     <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      exp_cnt_q  <= exp_cnt_d;
      r_q        <= r_d;
      negative_q <= negative_d;
      zero_q     <= zero_d;
      inexact_q  <= inexact_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = (x == 16'd0) ? ST_PACK : ST_NORM;
      ST_NORM: if (mag_q[15]) state_d = ST_PACK;
      ST_PACK: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sign_d     = sign_q;
    mag_d      = mag_q;
    exp_cnt_d  = exp_cnt_q;
    r_d        = r_q;
    negative_d = negative_q;
    zero_d     = zero_q;
    inexact_d  = inexact_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d    = x[15];
          // 16-bit wrap makes -32768 come out as 16'h8000, which is the right magnitude
          mag_d     = x[15] ? (16'd0 - x) : x;
          exp_cnt_d = EXP_CNT_INIT;
        end
      end
      ST_NORM: begin
        if (!mag_q[15]) begin
          mag_d     = {mag_q[14:0], 1'b0};
          exp_cnt_d = exp_cnt_q - 1'b1;
        end
      end
      ST_PACK: begin
        r_d        = pack_r;
        negative_d = pack_r[15];
        zero_d     = (mag_q == 16'd0);
        inexact_d  = pack_inexact;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !reset;
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    r         = r_q;
    negative  = negative_q;
    zero      = zero_q;
    inexact   = inexact_q;
  end

endmodule
